ponto_fixo_seq: RTL and testbench

Parametrised, sequential signed fixed-point arithmetic unit, QINT_BITS.FRAC_BITS two's complement, supporting add, subtract and multiply. It extends the combinational Q4.4 add/sub adder with three things that adder lacks: generic word width, a multi-cycle shift-add multiplier, and valid/ready handshakes on both input and output. It sits between an operand source and a result consumer in the fixed-point datapath. Optional saturation is available.

---
 rtl/ponto_fixo_seq.sv | 167 ++++++++++++++++
 tb/tb_ponto_fixo_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ponto_fixo_seq.sv
// ponto_fixo_seq: sequential signed Q(INT.FRAC) add/sub/mul unit.
// Define FIXED_SAT_EN to clamp results on overflow instead of wrapping.
module ponto_fixo_seq #(
    parameter int INT_BITS  = 4,
    parameter int FRAC_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0] a,
    input  logic [INT_BITS+FRAC_BITS-1:0] b,
    input  logic [1:0]                    op,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0] result,
    output logic                          overflow,
    output logic                          err
);
    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state_q, state_d;

    logic [W-1:0]   res_q;
    logic           ovf_q;
    logic           err_q;
    logic           neg_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] acc_q;

    logic           sub;
    logic [W-1:0]   bx;
    logic [W:0]     sum_as;
    logic           cin_msb;
    logic           ovf_as;
    logic [W-1:0]   res_as;

    assign sub     = op[0];
    assign bx      = b ^ {W{sub}};
    assign sum_as  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    assign cin_msb = sum_as[W-1] ^ a[W-1] ^ bx[W-1];
    assign ovf_as  = sum_as[W] ^ cin_msb;

`ifdef FIXED_SAT_EN
    assign res_as = !ovf_as    ? sum_as[W-1:0] :
                    sum_as[W]  ? MINV : MAXV;
`else
    assign res_as = sum_as[W-1:0];
`endif

    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] acc_nx;
    logic [2*W-1:0] mag_q;
    logic [2*W-1:0] sp;
    logic [INT_BITS:0] hi;
    logic           ovf_mul;
    logic [W-1:0]   res_mul;

    assign mag_a  = a[W-1] ? -a : a;
    assign mag_b  = b[W-1] ? -b : b;
    assign pp     = mplier_q[0] ? mcand_q : '0;
    assign acc_nx = acc_q + pp;
    // magnitude truncated before the sign is applied: rounds toward zero
    assign mag_q  = acc_nx >> FRAC_BITS;
    assign sp     = neg_q ? -mag_q : mag_q;
    assign hi     = sp[2*W-1:W-1];
    assign ovf_mul = !((&hi) || !(|hi));

`ifdef FIXED_SAT_EN
    assign res_mul = !ovf_mul ? sp[W-1:0] :
                     neg_q    ? MINV : MAXV;
`else
    assign res_mul = sp[W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = (op == 2'b10) ? MUL : DONE;
            end
            MUL: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        unique case (op)
                            2'b00, 2'b01: begin
                                res_q <= res_as;
                                ovf_q <= ovf_as;
                                err_q <= 1'b0;
                            end
                            2'b10: begin
                                mcand_q  <= {{W{1'b0}}, mag_a};
                                mplier_q <= mag_b;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                neg_q    <= a[W-1] ^ b[W-1];
                                err_q    <= 1'b0;
                            end
                            default: begin
                                res_q <= '0;
                                ovf_q <= 1'b0;
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        res_q <= res_mul;
                        ovf_q <= ovf_mul;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = res_q;
    assign overflow = ovf_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ponto_fixo_seq.sv
// Bench for ponto_fixo_seq: directed table, corner sequences and
// randomized operations against an integer-arithmetic reference model.
module tb_ponto_fixo_seq;
    localparam int IB = 4;
    localparam int FB = 4;
    localparam int W  = IB + FB;
`ifdef FIXED_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         err;

    int pass_cnt = 0;
    int total    = 0;

    ponto_fixo_seq #(.INT_BITS(IB), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] r;
        logic         ov;
        logic         er;
        int           lat;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        else
            pass_cnt++;
    endtask

    function automatic void model(input logic [W-1:0] ta,
                                  input logic [W-1:0] tbv,
                                  input logic [1:0] top,
                                  output logic [W-1:0] r,
                                  output logic ov, output logic er);
        logic signed [W-1:0] xa, xb;
        int sa, sb, ex, ma, mb, q;
        xa = ta; xb = tbv; sa = xa; sb = xb;
        er = 1'b0;
        ex = 0;
        case (top)
            2'b00: ex = sa + sb;
            2'b01: ex = sa - sb;
            2'b10: begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = (ma * mb) / (1 << FB);
                ex = ((sa < 0) != (sb < 0)) ? -q : q;
            end
            default: er = 1'b1;
        endcase
        ov = (ex > (1 << (W-1)) - 1) || (ex < -(1 << (W-1)));
        if (ov && SAT)
            r = (ex < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            r = ex[W-1:0];
    endfunction

    task automatic run_op(input string nm, input logic [W-1:0] ta,
                          input logic [W-1:0] tbv, input logic [1:0] top,
                          input logic [W-1:0] er, input logic eo,
                          input logic ee, input int el);
        int g = 0;
        int lat = 1;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk({nm, ".ready_to"}, 32'(g < 50), 1);
        a = ta; b = tbv; op = top; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, ".lat"}, 32'(lat), 32'(el));
        chk({nm, ".res"}, 32'(result), 32'(er));
        chk({nm, ".ovf"}, 32'(overflow), 32'(eo));
        chk({nm, ".err"}, 32'(err), 32'(ee));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, ".vld_drop"}, 32'(out_valid), 0);
        chk({nm, ".rdy_back"}, 32'(in_ready), 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rr;
        logic [1:0]   rop;
        logic         rov, rer;

        tbl[0]  = '{8'h18, 8'h28, 2'b00, 8'h40, 0, 0, 1};
        tbl[1]  = '{8'h10, 8'h30, 2'b01, 8'hE0, 0, 0, 1};
        tbl[2]  = '{8'h70, 8'h20, 2'b00, SAT ? 8'h7F : 8'h90, 1, 0, 1};
        tbl[3]  = '{8'h18, 8'h28, 2'b10, 8'h3C, 0, 0, 9};
        tbl[4]  = '{8'hF0, 8'h28, 2'b10, 8'hD8, 0, 0, 9};
        tbl[5]  = '{8'h40, 8'h40, 2'b10, SAT ? 8'h7F : 8'h00, 1, 0, 9};
        tbl[6]  = '{8'h55, 8'hAA, 2'b11, 8'h00, 0, 1, 1};
        tbl[7]  = '{8'h80, 8'h10, 2'b01, SAT ? 8'h80 : 8'h70, 1, 0, 1};
        tbl[8]  = '{8'h80, 8'h80, 2'b10, SAT ? 8'h7F : 8'h00, 1, 0, 9};
        tbl[9]  = '{8'h80, 8'h01, 2'b10, 8'hF8, 0, 0, 9};
        tbl[10] = '{8'hFF, 8'h01, 2'b10, 8'h00, 0, 0, 9};
        tbl[11] = '{8'h80, 8'h10, 2'b10, 8'h80, 0, 0, 9};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.result", 32'(result), 0);
        chk("rst.overflow", 32'(overflow), 0);
        chk("rst.err", 32'(err), 0);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
                   tbl[i].r, tbl[i].ov, tbl[i].er, tbl[i].lat);

        // backpressure: result held, second request waits for IDLE
        a = 8'h18; b = 8'h28; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h30; op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(out_valid), 1);
            chk("bp.res", 32'(result), 32'h40);
            chk("bp.rdy", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.idle_rdy", 32'(in_ready), 1);
        chk("bp.idle_vld", 32'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.2nd_vld", 32'(out_valid), 1);
        chk("bp.2nd_res", 32'(result), 32'hE0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset in the middle of a multiply
        a = 8'h18; b = 8'h28; op = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst.vld", 32'(out_valid), 0);
        chk("mrst.rdy", 32'(in_ready), 1);
        chk("mrst.res", 32'(result), 0);
        chk("mrst.ovf", 32'(overflow), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("mrst.still_idle", 32'(out_valid), 0);
        run_op("mrst.add", 8'h18, 8'h28, 2'b00, 8'h40, 0, 0, 1);

        for (int i = 0; i < 60; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 2'($urandom_range(0, 3));
            model(ra, rb, rop, rr, rov, rer);
            run_op($sformatf("rnd%0d", i), ra, rb, rop, rr, rov, rer,
                   (rop == 2'b10) ? W + 1 : 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
